icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache between the fetch stage (upstream consumer) and the memory controller's instruction-fetch port (downstream).
- Hits return one 32-bit instruction word with 1-cycle latency.
- Misses refill a whole line as a sequence of word requests on the MemCtrl fetch handshake, then answer the pending fetch.
- Speculation flush (rollback) cancels any in-flight request without corrupting the cache contents.

Parameters:
- INDEX_W, 4, index bits; number of lines = 2^INDEX_W (16).
- OFFSET_W, 2, word-offset bits; words per line = 2^OFFSET_W (4).
- ADDR_W, 32, address/PC width.
- DATA_W, 32, instruction word width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; when low the block freezes
- rollback  in  1  speculation flush from the commit stage
- if_req  in  1  fetch requests the word at if_pc; held until if_done
- if_pc  in  ADDR_W  fetch address, word aligned (bits [1:0] ignored)
- if_done  out  1  one-cycle pulse; if_inst is valid
- if_inst  out  DATA_W  instruction word for the request
- mc_en  out  1  word fetch request to MemCtrl
- mc_pc  out  ADDR_W  word address of the MemCtrl request
- mc_done  in  1  MemCtrl pulse; mc_data is valid
- mc_data  in  DATA_W  fetched word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Address split: offset = if_pc[OFFSET_W+1:2], index = next INDEX_W bits, tag = if_pc[ADDR_W-1:OFFSET_W+INDEX_W+2].
- Reset: all valid bits cleared; state IDLE; if_done=0, if_inst=0, mc_en=0, mc_pc=0; refill counter=0. Tag/data arrays are not cleared.
- rdy low: no state, array or output register changes. rst takes priority over rdy.
- Priority each cycle: rst > rdy low > rollback > normal operation.
- State IDLE:
  - if_done is deasserted every cycle unless a hit is signalled this cycle.
  - if_req with valid[index] && tag match: the next cycle has if_done=1 and if_inst=data[index][offset]; stay in IDLE.
  - A new if_req is accepted only in a cycle where if_done=0, so each request is answered exactly once.
  - if_req on a miss: latch base = {tag,index,0}, req_off = offset, cnt=0; go to REQ.
- State REQ:
  - mc_en=1, mc_pc=base+(cnt<<2).
  - On mc_done: store mc_data into the line buffer word cnt, drop mc_en, go to GAP.
- State GAP:
  - One cycle with mc_en=0, required by the MemCtrl handshake.
  - cnt!=last (2^OFFSET_W-1): cnt++, go to REQ.
  - cnt==last: write the line buffer into data[index], tag[index], set valid[index]; go to RESP.
- State RESP:
  - if_done=1, if_inst=line buffer word req_off, for exactly one cycle; go to IDLE.
  - If the line index is requested again immediately, the newly installed line must hit.
- Word order and counter:
  - Refill words are always requested from offset 0 upward, not critical-word-first.
  - cnt is OFFSET_W bits and never wraps within a refill.
- Rollback, any state:
  - Next cycle: IDLE, mc_en=0, if_done=0.
  - A partial refill is discarded; no valid, tag or data write occurs.
  - A hit response scheduled for the following cycle is suppressed.
  - if_req in the same cycle as rollback is ignored.
  - An mc_done arriving in the same cycle as rollback is dropped.
- Valid bits are never cleared except by reset; there is no self-modifying-code support.
- if_pc must not change while if_req is pending unless rollback occurs; behaviour otherwise is undefined.
- Simultaneous mc_done in GAP/IDLE/RESP cannot occur (MemCtrl only answers while mc_en=1); it is ignored if seen.

Decomposition:
- Shared package or header holds: ADDR_W, DATA_W, INDEX_W and OFFSET_W defaults; the derived TAG_W; the state encoding IDLE/REQ/GAP/RESP (2 bits).
- Sub-module icache_array: tag, valid and data storage.
  - Combinational read port: hit, word.
  - Synchronous line-write port.
  - Synchronous valid clear on rst.
- The top level holds the FSM, refill buffer, counter and handshake.

Test Plan:
- Reset, then if_req at 0x00000008 -> mc_pc sequence 0x0, 0x4, 0x8, 0xC, each separated by one mc_en=0 cycle; if_done one cycle after the 4th GAP with if_inst = word returned for 0x8.
- Subsequent if_req at 0x0000000C -> if_done next cycle, correct word, mc_en stays 0 throughout.
- Conflict: after 0x0 is resident, request 0x00000100 (same index, different tag) -> full refill 0x100–0x10C; a following request to 0x0 misses and refills again.
- Rollback asserted after the 2nd mc_done -> next cycle mc_en=0, state IDLE; re-request 0x4 -> refill restarts at 0x0 with 4 requests, and line 0 was never marked valid in between.
- Hit request with rdy low for 3 cycles -> if_done and mc_en held, no progress; on rdy high the response completes exactly once.
- rst asserted mid-refill with rdy=1 -> all outputs 0 next cycle; a prior hit address now misses.

Source files
------------

// File: rtl/icache_pkg.sv
// icache shared definitions: default geometry and the
// refill state encoding.
package icache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/icache_array.sv
// icache tag/valid/data storage: combinational lookup,
// synchronous whole-line install.
module icache_array #(
    parameter int ADDR_W   = icache_pkg::ADDR_W,
    parameter int DATA_W   = icache_pkg::DATA_W,
    parameter int INDEX_W  = icache_pkg::INDEX_W,
    parameter int OFFSET_W = icache_pkg::OFFSET_W,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rdy,
    input  logic [INDEX_W-1:0]                   rd_idx,
    input  logic [OFFSET_W-1:0]                  rd_off,
    input  logic [TAG_W-1:0]                     rd_tag,
    output logic                                 hit,
    output logic [DATA_W-1:0]                    rd_word,
    input  logic                                 we,
    input  logic [INDEX_W-1:0]                   wr_idx,
    input  logic [TAG_W-1:0]                     wr_tag,
    input  logic [(1<<OFFSET_W)-1:0][DATA_W-1:0] wr_line
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]                     valid;
    logic [TAG_W-1:0]                     tag_mem  [LINES];
    logic [(1<<OFFSET_W)-1:0][DATA_W-1:0] data_mem [LINES];

    assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_word = data_mem[rd_idx][rd_off];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (rdy && we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // tag/data stay uninitialised; valid gates every use of them
    always_ff @(posedge clk) begin
        if (!rst && rdy && we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: 1-cycle hits, in-order
// word-by-word line refill over the MemCtrl fetch handshake.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W   = icache_pkg::ADDR_W,
    parameter int DATA_W   = icache_pkg::DATA_W,
    parameter int INDEX_W  = icache_pkg::INDEX_W,
    parameter int OFFSET_W = icache_pkg::OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    output logic              mc_en,
    output logic [ADDR_W-1:0] mc_pc,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_data
);

    localparam int LINE_W = ADDR_W - OFFSET_W - 2;
    localparam int TAG_LW = LINE_W - INDEX_W;
    localparam int WORDS  = 1 << OFFSET_W;

    state_t                         state, state_n;
    logic [LINE_W-1:0]              line, line_n;
    logic [OFFSET_W-1:0]            req_off, req_off_n;
    logic [OFFSET_W-1:0]            cnt, cnt_n;
    logic [WORDS-1:0][DATA_W-1:0]   lbuf;
    logic                           done_n, en_n;
    logic [DATA_W-1:0]              inst_n;
    logic [ADDR_W-1:0]              pc_n;
    logic                           buf_we, arr_we;
    logic                           hit;
    logic [DATA_W-1:0]              hit_word;
    logic                           unused_pc;

    assign unused_pc = ^if_pc[1:0];

    icache_array #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .OFFSET_W(OFFSET_W),
        .TAG_W   (TAG_LW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .rd_idx (if_pc[OFFSET_W+2 +: INDEX_W]),
        .rd_off (if_pc[OFFSET_W+1:2]),
        .rd_tag (if_pc[ADDR_W-1 -: TAG_LW]),
        .hit    (hit),
        .rd_word(hit_word),
        .we     (arr_we),
        .wr_idx (line[INDEX_W-1:0]),
        .wr_tag (line[LINE_W-1:INDEX_W]),
        .wr_line(lbuf)
    );

    always_comb begin
        state_n   = state;
        line_n    = line;
        req_off_n = req_off;
        cnt_n     = cnt;
        done_n    = 1'b0;
        inst_n    = if_inst;
        en_n      = mc_en;
        pc_n      = mc_pc;
        buf_we    = 1'b0;
        arr_we    = 1'b0;
        if (rollback) begin
            state_n = IDLE;
            en_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // if_done high means this request was just answered
                    if (if_req && !if_done) begin
                        if (hit) begin
                            done_n = 1'b1;
                            inst_n = hit_word;
                        end else begin
                            line_n    = if_pc[ADDR_W-1:OFFSET_W+2];
                            req_off_n = if_pc[OFFSET_W+1:2];
                            cnt_n     = '0;
                            en_n      = 1'b1;
                            pc_n      = {if_pc[ADDR_W-1:OFFSET_W+2],
                                         {OFFSET_W{1'b0}}, 2'b00};
                            state_n   = REQ;
                        end
                    end
                end
                REQ: begin
                    if (mc_done) begin
                        buf_we  = 1'b1;
                        en_n    = 1'b0;
                        state_n = GAP;
                    end
                end
                GAP: begin
                    if (cnt != '1) begin
                        cnt_n   = cnt + 1'b1;
                        en_n    = 1'b1;
                        pc_n    = {line, cnt_n, 2'b00};
                        state_n = REQ;
                    end else begin
                        arr_we  = 1'b1;
                        done_n  = 1'b1;
                        inst_n  = lbuf[req_off];
                        state_n = RESP;
                    end
                end
                RESP: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            if_done <= 1'b0;
            if_inst <= '0;
            mc_en   <= 1'b0;
            mc_pc   <= '0;
        end else if (rdy) begin
            state   <= state_n;
            cnt     <= cnt_n;
            if_done <= done_n;
            if_inst <= inst_n;
            mc_en   <= en_n;
            mc_pc   <= pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            line    <= line_n;
            req_off <= req_off_n;
            if (buf_we) begin
                lbuf[cnt] <= mc_data;
            end
        end
    end

endmodule
